// File: rtl/hazard_pkg.sv
// Shared types and constants for the EM-stage hazard/forwarding controller.
package hazard_pkg;

  // Controller states: normal operation, or holding the pipe for data memory.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  // EM operand source selects.
  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_HIST = 2'b10;

  // Default configuration.
  localparam int unsigned REG_ADDR_W_DEF  = 3;
  localparam int unsigned MEM_TIMEOUT_DEF = 16;
  localparam int unsigned PERF_W_DEF      = 16;

endpackage

// File: rtl/fwd_sel.sv
// Per-operand forwarding source select: WB result beats the retired-write history.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  wb_regwrite_i,
  input  logic [REG_ADDR_W-1:0] wb_addr_i,
  input  logic                  hist_valid_i,
  input  logic [REG_ADDR_W-1:0] hist_addr_i,
  input  logic [REG_ADDR_W-1:0] em_addr_i,
  output logic [1:0]            sel_o
);

  // Priority compare; register 0 is treated like any other register.
  always_comb begin
    sel_o = FWD_RF;
    if (wb_regwrite_i && (wb_addr_i == em_addr_i)) begin
      sel_o = FWD_WB;
    end else if (hist_valid_i && (hist_addr_i == em_addr_i)) begin
      sel_o = FWD_HIST;
    end
  end

endmodule

// File: rtl/em_hazard_ctrl.sv
// Hazard and forwarding controller for the 4-stage (IF, ID, EM, WB) pipeline.
// Optional performance counters are built only when HAZ_PERF_EN is defined;
// otherwise stall_cycles_o / bubble_count_o are tied to zero.
module em_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int unsigned PERF_W      = PERF_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] id_rs_addr_i,
  input  logic [REG_ADDR_W-1:0] id_rt_addr_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] em_rs_addr_i,
  input  logic [REG_ADDR_W-1:0] em_rt_addr_i,
  input  logic [REG_ADDR_W-1:0] em_write_addr_i,
  input  logic                  em_regwrite_i,
  input  logic                  em_memread_i,
  input  logic                  em_memwrite_i,
  input  logic [REG_ADDR_W-1:0] wb_write_addr_i,
  input  logic                  wb_regwrite_i,
  input  logic                  mem_ready_i,
  output logic                  mem_req_o,
  output logic                  freeze_o,
  output logic                  stall_id_o,
  output logic                  bubble_o,
  output logic [1:0]            fwd_rs_sel_o,
  output logic [1:0]            fwd_rt_sel_o,
  output logic                  mem_timeout_o,
  output logic [PERF_W-1:0]     stall_cycles_o,
  output logic [PERF_W-1:0]     bubble_count_o
);

  localparam int unsigned    CNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  hist_valid_q, hist_valid_d;
  logic [REG_ADDR_W-1:0] hist_addr_q, hist_addr_d;
  logic                  mem_timeout_q, mem_timeout_d;

  logic                  macc_c, lu_c;
  logic                  req_c, freeze_c, stall_c, bubble_c;
  logic [1:0]            fwd_rs_c, fwd_rt_c;

  // Memory access and load-use hazard detection between ID and EM.
  always_comb begin
    macc_c = em_memread_i | em_memwrite_i;
    lu_c   = em_memread_i & em_regwrite_i &
             ((id_uses_rs_i & (em_write_addr_i == id_rs_addr_i)) |
              (id_uses_rt_i & (em_write_addr_i == id_rt_addr_i)));
  end

  // Next-state and pipeline-control decode; a memory wait outranks load-use.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mem_timeout_d = mem_timeout_q;
    req_c         = 1'b0;
    freeze_c      = 1'b0;
    stall_c       = 1'b0;
    bubble_c      = 1'b0;
    case (state_q)
      IDLE: begin
        req_c = macc_c;
        if (macc_c && !mem_ready_i) begin
          freeze_c = 1'b1;
          stall_c  = 1'b1;
          state_d  = MEM_WAIT;
          cnt_d    = CNT_W'(1);
        end else if (lu_c) begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
      end
      MEM_WAIT: begin
        req_c    = 1'b1;
        freeze_c = 1'b1;
        stall_c  = 1'b1;
        if (mem_ready_i) begin
          freeze_c = 1'b0;
          stall_c  = 1'b0;
          state_d  = IDLE;
          cnt_d    = '0;
        end else if (cnt_q == CNT_LAST) begin
          // Forced release: flag it and let the pipe move on.
          mem_timeout_d = 1'b1;
          freeze_c      = 1'b0;
          stall_c       = 1'b0;
          state_d       = IDLE;
          cnt_d         = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // One-entry history of the last retired write; held while the pipe is frozen.
  always_comb begin
    hist_valid_d = hist_valid_q;
    hist_addr_d  = hist_addr_q;
    if (!freeze_c) begin
      hist_valid_d = wb_regwrite_i;
      hist_addr_d  = wb_write_addr_i;
    end
  end

  // Controller state registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      hist_valid_q  <= 1'b0;
      hist_addr_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hist_valid_q  <= hist_valid_d;
      hist_addr_q   <= hist_addr_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rs (
    .wb_regwrite_i (wb_regwrite_i),
    .wb_addr_i     (wb_write_addr_i),
    .hist_valid_i  (hist_valid_q),
    .hist_addr_i   (hist_addr_q),
    .em_addr_i     (em_rs_addr_i),
    .sel_o         (fwd_rs_c)
  );

  fwd_sel #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_rt (
    .wb_regwrite_i (wb_regwrite_i),
    .wb_addr_i     (wb_write_addr_i),
    .hist_valid_i  (hist_valid_q),
    .hist_addr_i   (hist_addr_q),
    .em_addr_i     (em_rt_addr_i),
    .sel_o         (fwd_rt_c)
  );

  // Combinational outputs are forced low while reset is asserted.
  assign mem_req_o     = req_c    & ~rst_i;
  assign freeze_o      = freeze_c & ~rst_i;
  assign stall_id_o    = stall_c  & ~rst_i;
  assign bubble_o      = bubble_c & ~rst_i;
  assign fwd_rs_sel_o  = rst_i ? FWD_RF : fwd_rs_c;
  assign fwd_rt_sel_o  = rst_i ? FWD_RF : fwd_rt_c;
  assign mem_timeout_o = mem_timeout_q;

`ifdef HAZ_PERF_EN
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating freeze-cycle and bubble counters.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (freeze_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + PERF_W'(1);
    end
    if (bubble_c && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + PERF_W'(1);
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cnt_q;
  assign bubble_count_o = bubble_cnt_q;
`else
  assign stall_cycles_o = '0;
  assign bubble_count_o = '0;
`endif

endmodule
